imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Parametrised, pipelined successor of the single-cycle immediate extender. Covers all RISC-V
//  immediate formats: I, S, B, J, U and CSR-Z. Format comes from an explicit imm_src code or is
//  decoded from the opcode. Results are buffered in a DEPTH-entry FIFO behind a valid/ready
//  handshake. Sits between fetch/decode and execute in the pipelined core.
// PARAMETERS
//  XLEN        32  output width; 32 or 64, sign extension fills to XLEN
//  DEPTH       2   output FIFO entries; power of 2, >=2
//  AUTO_DECODE 0   1: format decoded from in_instr[6:0]; 0: format taken from in_imm_src
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst          in   1     synchronous, active-high reset
//  in_valid     in   1     in_instr/in_imm_src valid
//  in_ready     out  1     block can accept; transfer when in_valid&&in_ready
//  in_instr     in   32    raw instruction word
//  in_imm_src   in   3     000 I, 001 S, 010 B, 011 J, 100 U, 101 Z, 11x illegal (ignored if AUTO_DECODE)
//  out_valid    out  1     FIFO head valid
//  out_ready    in   1     consumer accepts; pop when out_valid&&out_ready
//  out_imm      out  XLEN  extended immediate of FIFO head
//  out_fmt      out  3     resolved format code of head (same encoding as in_imm_src)
//  out_illegal  out  1     head had illegal format/opcode
//  err_count    out  16    number of accepted illegal entries, saturating
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, out_valid 0, out_imm 0, out_fmt 0, out_illegal 0, err_count 0, in_ready 1.
//  Formats (s = sign bit instr[31], replicated to XLEN):
//   I {s,i[30:20]}; S {s,i[30:25],i[11:7]}; B {s,i[7],i[30:25],i[11:8],0};
//   J {s,i[19:12],i[20],i[30:21],0}; U {s,i[30:12],12'b0}; sign-extended above bit 31 when XLEN=64.
//   Z zero-extended i[19:15].
//   Illegal: imm 0, out_illegal 1.
//  AUTO_DECODE opcodes:
//   0000011/0010011/0011011/1100111 -> I; 0100011 -> S; 1100011 -> B; 1101111 -> J;
//   0110111/0010111 -> U; 1110011 -> Z if funct3[2]=1, else I; anything else illegal.
//  Latency: entry accepted at edge N is visible at the head after edge N when the FIFO was empty.
//   out_valid rises in cycle N+1. There is no combinational in->out path.
//  in_ready = (count < DEPTH); registered, so no dependence on out_ready.
//  Push and pop in the same cycle: count unchanged, both pointers advance.
//   Legal whenever in_ready=1 and out_valid=1.
//  Full (count==DEPTH): in_ready 0, in_valid ignored. A pop in that cycle drops count.
//   in_ready returns to 1 the next cycle.
//  Empty: out_valid 0. out_imm/out_fmt/out_illegal hold their last value (0 after reset);
//   the bench must not check them.
//  Stall: while out_valid && !out_ready, all head outputs stay stable.
//  Pointers wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
//  err_count increments by 1 on each accepted illegal entry and saturates at 16'hFFFF.
//  Reset mid-stream: pending entries are discarded and the next cycle shows reset values.
//   A transfer in the reset cycle is ignored.
// TESTING
//  AUTO=0, src=000, instr 32'hFFC12083 (lw x1,-4(x2)) -> out_imm 32'hFFFFFFFC one cycle later, fmt 000.
//  AUTO=1 sequence S 32'hFE112E23, B 32'hFE000CE3, U 32'h123450B7, J 32'h0010006F
//   -> out_imm FFFFFFFC, FFFFFFF8, 12345000, 00000800, in that order.
//  XLEN=64, AUTO=1, instr 32'h800000B7 (lui x1,0x80000) -> out_imm 64'hFFFFFFFF80000000.
//  DEPTH=2, out_ready=0, push 3 back-to-back -> in_ready low after 2nd push, 3rd not taken.
//   Raise out_ready -> both pop in order; simultaneous push/pop keeps count.
//  AUTO=1 opcode 7'b1111111, and AUTO=0 src=110 -> out_illegal 1, imm 0, err_count steps 0->1->2.
//   Force err_count to FFFF, then push illegal -> stays FFFF.
//  Fill FIFO, assert rst one cycle mid-stream -> next cycle out_valid 0, in_ready 1, err_count 0.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extender (I/S/B/J/U/CSR-Z) with a registered output FIFO.
// The format comes from in_imm_src or is decoded from the opcode.
module imm_gen_pipe #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 2,
   parameter int AUTO_DECODE = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [2:0]      in_imm_src,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   output logic [15:0]     err_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int EW = XLEN + 4;

   localparam logic [2:0] FMT_I   = 3'd0;
   localparam logic [2:0] FMT_S   = 3'd1;
   localparam logic [2:0] FMT_B   = 3'd2;
   localparam logic [2:0] FMT_J   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_Z   = 3'd5;
   localparam logic [2:0] FMT_BAD = 3'd7;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [2:0]      fmt_dec;
   logic            illegal;
   logic [31:0]     imm_raw;
   logic [XLEN-1:0] imm_ext;
   logic [EW-1:0]   entry_new;

   logic [EW-1:0]   mem_reg [DEPTH];
   logic [EW-1:0]   head_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [15:0]     err_count_reg;

   logic            push;
   logic            pop;
   logic            unused_inputs;

   // Only one of opcode / imm_src is meaningful for a given AUTO_DECODE setting.
   assign unused_inputs = ^{in_instr[6:0], in_imm_src};

   generate
      if (AUTO_DECODE != 0) begin : g_auto
         always_comb begin
            case (in_instr[6:0])
               7'b0000011, 7'b0010011,
               7'b0011011, 7'b1100111: fmt_dec = FMT_I;
               7'b0100011:             fmt_dec = FMT_S;
               7'b1100011:             fmt_dec = FMT_B;
               7'b1101111:             fmt_dec = FMT_J;
               7'b0110111, 7'b0010111: fmt_dec = FMT_U;
               7'b1110011:             fmt_dec = in_instr[14] ? FMT_Z : FMT_I;
               default:                fmt_dec = FMT_BAD;
            endcase
         end
      end else begin : g_src
         assign fmt_dec = in_imm_src;
      end
   endgenerate

   assign illegal = (fmt_dec > FMT_Z);

   always_comb begin
      case (fmt_dec)
         FMT_I:   imm_raw = {{21{in_instr[31]}}, in_instr[30:20]};
         FMT_S:   imm_raw = {{21{in_instr[31]}}, in_instr[30:25], in_instr[11:7]};
         FMT_B:   imm_raw = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
         FMT_J:   imm_raw = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
         FMT_U:   imm_raw = {in_instr[31:12], 12'b0};
         FMT_Z:   imm_raw = {27'b0, in_instr[19:15]};
         default: imm_raw = 32'b0;
      endcase
   end

   // Bit 31 of the Z form is always 0, so a plain sign extension covers every format.
   assign imm_ext   = XLEN'($signed(imm_raw));
   assign entry_new = {illegal, fmt_dec, imm_ext};

   assign in_ready    = (count_reg != FULL);
   assign out_valid   = (count_reg != '0);
   assign push        = in_valid && in_ready;
   assign pop         = out_valid && out_ready;

   assign out_illegal = head_reg[EW-1];
   assign out_fmt     = head_reg[EW-2 -: 3];
   assign out_imm     = head_reg[XLEN-1:0];
   assign err_count   = err_count_reg;

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_reg[wr_ptr_reg] <= entry_new;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         head_reg      <= '0;
         err_count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase

         // The head register always mirrors the entry that will sit at rd_ptr after this edge.
         if (pop) begin
            if (count_reg > CW'(1)) begin
               head_reg <= mem_reg[rd_ptr_reg + AW'(1)];
            end else if (push) begin
               head_reg <= entry_new;
            end
         end else if (push && (count_reg == '0)) begin
            head_reg <= entry_new;
         end

         if (push && illegal && (err_count_reg != 16'hFFFF)) begin
            err_count_reg <= err_count_reg + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (manual/32, auto/32, auto/64) checked
// through a per-instance scoreboard filled on acceptance and drained on pop.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]  iv;
   logic [2:0]  ordy;
   logic [31:0] ins [3];
   logic [2:0]  src [3];
   ent_t        dexp [3];

   logic [2:0]  irdy;
   logic [2:0]  ov;
   logic [2:0]  ill;
   logic [31:0] imm0, imm1;
   logic [63:0] imm2;
   logic [2:0]  fmt0, fmt1, fmt2;
   logic [15:0] ec0, ec1, ec2;

   ent_t q0 [$];
   ent_t q1 [$];
   ent_t q2 [$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111,
                            7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111,
                            7'b0010111, 7'b1110011, 7'b1111111, 7'b0000000};

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_instr(ins[0]), .in_imm_src(src[0]), .out_valid(ov[0]),
      .out_ready(ordy[0]), .out_imm(imm0), .out_fmt(fmt0),
      .out_illegal(ill[0]), .err_count(ec0));

   imm_gen_pipe #(.XLEN(32), .DEPTH(2), .AUTO_DECODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_instr(ins[1]), .in_imm_src(src[1]), .out_valid(ov[1]),
      .out_ready(ordy[1]), .out_imm(imm1), .out_fmt(fmt1),
      .out_illegal(ill[1]), .err_count(ec1));

   imm_gen_pipe #(.XLEN(64), .DEPTH(2), .AUTO_DECODE(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_instr(ins[2]), .in_imm_src(src[2]), .out_valid(ov[2]),
      .out_ready(ordy[2]), .out_imm(imm2), .out_fmt(fmt2),
      .out_illegal(ill[2]), .err_count(ec2));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] get_imm(input int k);
      case (k)
         0:       return {32'b0, imm0};
         1:       return {32'b0, imm1};
         default: return imm2;
      endcase
   endfunction

   function automatic logic [2:0] get_fmt(input int k);
      case (k)
         0:       return fmt0;
         1:       return fmt1;
         default: return fmt2;
      endcase
   endfunction

   function automatic logic [15:0] get_ec(input int k);
      case (k)
         0:       return ec0;
         1:       return ec1;
         default: return ec2;
      endcase
   endfunction

   function automatic int qsize(input int k);
      case (k)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpush(input int k, input ent_t e);
      case (k)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic qpop(input int k, output ent_t e);
      case (k)
         0:       e = q0.pop_front();
         1:       e = q1.pop_front();
         default: e = q2.pop_front();
      endcase
   endtask

   function automatic ent_t mk(input logic [63:0] imm, input logic [2:0] fmt, input logic il);
      ent_t e;
      e.imm = imm;
      e.fmt = fmt;
      e.ill = il;
      return e;
   endfunction

   // Reference model built from shifted fields rather than concatenations.
   function automatic ent_t model(input logic [31:0] i, input logic [2:0] s,
                                  input bit auto, input bit x64);
      ent_t        e;
      logic [63:0] ones;
      logic [2:0]  f;
      ones = i[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
      if (auto) begin
         case (i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: f = 3'd0;
            7'b0100011:             f = 3'd1;
            7'b1100011:             f = 3'd2;
            7'b1101111:             f = 3'd3;
            7'b0110111, 7'b0010111: f = 3'd4;
            7'b1110011:             f = (i[14] == 1'b1) ? 3'd5 : 3'd0;
            default:                f = 3'd7;
         endcase
      end else begin
         f = s;
      end
      e.fmt = f;
      e.ill = (f >= 3'd6);
      case (f)
         3'd0: e.imm = (ones << 11) | 64'(i[30:20]);
         3'd1: e.imm = (ones << 11) | (64'(i[30:25]) << 5) | 64'(i[11:7]);
         3'd2: e.imm = (ones << 12) | (64'(i[7]) << 11) | (64'(i[30:25]) << 5)
                       | (64'(i[11:8]) << 1);
         3'd3: e.imm = (ones << 20) | (64'(i[19:12]) << 12) | (64'(i[20]) << 11)
                       | (64'(i[30:21]) << 1);
         3'd4: e.imm = (ones << 31) | (64'(i[30:12]) << 12);
         3'd5: e.imm = 64'(i[19:15]);
         default: e.imm = 64'h0;
      endcase
      if (!x64) e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
      return e;
   endfunction

   // Scoreboard: compare/pop on output handshake, push on input handshake.
   always @(negedge clk) begin
      ent_t e;
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            if (ov[k] && ordy[k]) begin
               if (qsize(k) == 0) begin
                  chk($sformatf("d%0d_spurious_valid", k), 64'(ov[k]), 64'h0);
               end else begin
                  qpop(k, e);
                  chk($sformatf("d%0d_imm", k), get_imm(k), e.imm);
                  chk($sformatf("d%0d_illegal", k), 64'(ill[k]), 64'(e.ill));
                  if (!e.ill) chk($sformatf("d%0d_fmt", k), 64'(get_fmt(k)), 64'(e.fmt));
               end
            end
            if (iv[k] && irdy[k]) qpush(k, dexp[k]);
         end
      end
   end

   task automatic drive(input int k, input logic [31:0] i, input logic [2:0] s, input ent_t e);
      iv[k]   = 1'b1;
      ins[k]  = i;
      src[k]  = s;
      dexp[k] = e;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int k, input logic [31:0] i, input logic [2:0] s, input ent_t e);
      int w;
      w = 0;
      drive(k, i, s, e);
      while (!irdy[k] && w < 50) begin
         w++;
         if (w == 4) ordy[k] = 1'b1;
         @(posedge clk); #1;
      end
      if (!irdy[k]) chk($sformatf("d%0d_send_timeout", k), 64'(irdy[k]), 64'h1);
      @(posedge clk); #1;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
   end

   initial begin
      logic [31:0] r;
      logic [2:0]  s;
      iv   = 3'b000;
      ordy = 3'b111;
      for (int k = 0; k < 3; k++) begin
         ins[k]  = 32'h0;
         src[k]  = 3'b0;
         dexp[k] = mk(64'h0, 3'd0, 1'b0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d_rst_valid", k), 64'(ov[k]), 64'h0);
         chk($sformatf("d%0d_rst_ready", k), 64'(irdy[k]), 64'h1);
         chk($sformatf("d%0d_rst_imm", k), get_imm(k), 64'h0);
         chk($sformatf("d%0d_rst_fmt", k), 64'(get_fmt(k)), 64'h0);
         chk($sformatf("d%0d_rst_ill", k), 64'(ill[k]), 64'h0);
         chk($sformatf("d%0d_rst_err", k), 64'(get_ec(k)), 64'h0);
      end

      // lw x1,-4(x2) with explicit I format, visible the cycle after acceptance
      send(0, 32'hFFC12083, 3'b000, mk(64'hFFFF_FFFC, 3'd0, 1'b0));
      iv[0] = 1'b0;
      chk("d0_latency_valid", 64'(ov[0]), 64'h1);
      step(1);

      send(1, 32'hFE112E23, 3'b000, mk(64'hFFFF_FFFC, 3'd1, 1'b0));
      send(1, 32'hFE000CE3, 3'b000, mk(64'hFFFF_FFF8, 3'd2, 1'b0));
      send(1, 32'h123450B7, 3'b000, mk(64'h1234_5000, 3'd4, 1'b0));
      send(1, 32'h0010006F, 3'b000, mk(64'h0000_0800, 3'd3, 1'b0));
      iv[1] = 1'b0;
      step(2);

      send(2, 32'h800000B7, 3'b000, mk(64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0));
      iv[2] = 1'b0;
      step(2);

      // illegal formats: err_count steps per accepted illegal entry
      send(0, 32'h12345678, 3'b110, mk(64'h0, 3'd6, 1'b1));
      iv[0] = 1'b0;
      chk("d0_err_1", 64'(ec0), 64'h1);
      send(0, 32'h87654321, 3'b111, mk(64'h0, 3'd7, 1'b1));
      iv[0] = 1'b0;
      chk("d0_err_2", 64'(ec0), 64'h2);
      send(1, 32'hFFFFFFFF, 3'b000, mk(64'h0, 3'd7, 1'b1));
      iv[1] = 1'b0;
      chk("d1_err_1", 64'(ec1), 64'h1);
      step(2);

      // saturation near the top of the counter
      force dut0.err_count_reg = 16'hFFFE;
      send(0, 32'h00000000, 3'b110, mk(64'h0, 3'd6, 1'b1));
      iv[0] = 1'b0;
      release dut0.err_count_reg;
      send(0, 32'h00000001, 3'b110, mk(64'h0, 3'd6, 1'b1));
      send(0, 32'h00000002, 3'b111, mk(64'h0, 3'd7, 1'b1));
      iv[0] = 1'b0;
      chk("d0_err_sat", 64'(ec0), 64'hFFFF);
      step(2);

      // fill with consumer stalled; third push must be refused
      ordy[1] = 1'b0;
      send(1, 32'h00500093, 3'b000, mk(64'h5, 3'd0, 1'b0));
      send(1, 32'hFFF00113, 3'b000, mk(64'hFFFF_FFFF, 3'd0, 1'b0));
      chk("d1_full_ready", 64'(irdy[1]), 64'h0);
      drive(1, 32'h0000A0B7, 3'b000, mk(64'h0000_A000, 3'd4, 1'b0));
      step(1);
      chk("d1_full_ready_hold", 64'(irdy[1]), 64'h0);
      chk("d1_stall_head", 64'(imm1), 64'h5);
      chk("d1_stall_valid", 64'(ov[1]), 64'h1);
      iv[1] = 1'b0;
      ordy[1] = 1'b1;
      step(1);
      chk("d1_ready_back", 64'(irdy[1]), 64'h1);
      step(1);
      chk("d1_drained", 64'(ov[1]), 64'h0);

      // simultaneous push and pop with one entry held
      ordy[1] = 1'b0;
      send(1, 32'h30015073, 3'b000, mk(64'h2, 3'd5, 1'b0));
      ordy[1] = 1'b1;
      drive(1, 32'h34202373, 3'b000, mk(64'h342, 3'd0, 1'b0));
      step(1);
      iv[1] = 1'b0;
      chk("d1_pushpop_valid", 64'(ov[1]), 64'h1);
      chk("d1_pushpop_ready", 64'(irdy[1]), 64'h1);
      step(1);
      chk("d1_pushpop_drain", 64'(ov[1]), 64'h0);

      // random manual-format traffic with a bursty consumer
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         s = 3'($urandom_range(0, 7));
         ordy[0] = ($urandom_range(0, 3) != 0);
         send(0, r, s, model(r, s, 1'b0, 1'b0));
      end
      iv[0] = 1'b0;
      ordy[0] = 1'b1;

      // random opcode-decoded traffic at XLEN=64
      for (int n = 0; n < 40; n++) begin
         r = $urandom;
         r[6:0] = ops[$urandom_range(0, 11)];
         ordy[2] = ($urandom_range(0, 3) != 0);
         send(2, r, 3'b000, model(r, 3'b000, 1'b1, 1'b1));
      end
      iv[2] = 1'b0;
      ordy[2] = 1'b1;
      step(4);

      // reset while full with a pending transfer
      ordy[1] = 1'b0;
      send(1, 32'h00100093, 3'b000, mk(64'h1, 3'd0, 1'b0));
      send(1, 32'h00200093, 3'b000, mk(64'h2, 3'd0, 1'b0));
      chk("d1_prerst_ready", 64'(irdy[1]), 64'h0);
      rst = 1'b1;
      drive(1, 32'h00300093, 3'b000, mk(64'h3, 3'd0, 1'b0));
      q0.delete();
      q1.delete();
      q2.delete();
      step(1);
      rst = 1'b0;
      iv[1] = 1'b0;
      chk("d1_midrst_valid", 64'(ov[1]), 64'h0);
      chk("d1_midrst_ready", 64'(irdy[1]), 64'h1);
      chk("d1_midrst_err", 64'(ec1), 64'h0);
      chk("d0_midrst_err", 64'(ec0), 64'h0);
      ordy[1] = 1'b1;
      step(1);
      chk("d1_midrst_still_empty", 64'(ov[1]), 64'h0);

      step(2);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("d%0d_sb_left", k), 64'(qsize(k)), 64'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
